// File: rtl/rtype_alu_exec.sv
// rtl/rtype_alu_exec.sv - R-type execution unit: beat-loaded instruction, register file, ALU, chunked result stream
module rtype_alu_exec #(
  parameter int XLEN  = 32,
  parameter int BUS_W = 8,
  parameter int NREGS = 32,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BUS_W-1:0] in_data,
  input  logic             rf_we,
  input  logic [4:0]       rf_waddr,
  input  logic [XLEN-1:0]  rf_wdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             illegal
);

  localparam int NBEATS = 32 / BUS_W;
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int NCH    = XLEN / OUT_W;
  localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SHW    = $clog2(XLEN);

  typedef enum logic [1:0] {S_LOAD, S_EXEC, S_DRAIN} state_e;

  state_e            state_q;
  logic [BW-1:0]     beat_q;
  logic [31:0]       instr_q;
  logic [XLEN-1:0]   sr_q;
  logic [CW-1:0]     chunk_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic [OUT_W-1:0]  out_data_q;
  logic              illegal_q;
  logic [XLEN-1:0]   rf_q [32];

  logic [5:0]        func;
  logic [4:0]        rd;
  logic [4:0]        rs2;
  logic [4:0]        rs1;
  logic [5:0]        opcode;
  logic [XLEN-1:0]   num1;
  logic [XLEN-1:0]   num2;
  logic [SHW-1:0]    sh;
  logic [SHW:0]      rsh;
  logic              bad;
  logic [XLEN-1:0]   res;
  logic              unused_instr;

  assign func         = instr_q[5:0];
  assign rd           = instr_q[15:11];
  assign rs2          = instr_q[20:16];
  assign rs1          = instr_q[25:21];
  assign opcode       = instr_q[31:26];
  assign unused_instr = ^instr_q[10:6];

  assign num1 = (rs1 == 5'd0) ? '0 : rf_q[rs1];
  assign num2 = (rs2 == 5'd0) ? '0 : rf_q[rs2];
  assign sh   = num2[SHW-1:0];
  // Complementary shift for rotates; sh=0 gives a full-width shift, which yields 0
  assign rsh  = (SHW+1)'(XLEN) - {1'b0, sh};

  assign bad = (opcode != 6'd0) || (func > 6'd17) ||
               (int'(rd) >= NREGS) || (int'(rs1) >= NREGS) || (int'(rs2) >= NREGS);

  always_comb begin
    res = '0;
    case (func)
      6'd0:  res = num1 + num2;
      6'd1:  res = num1 - num2;
      6'd2:  res = num1 & num2;
      6'd3:  res = num1 | num2;
      6'd4:  res = num1 ^ num2;
      6'd5:  res = num1 << sh;
      6'd6:  res = num1 >> sh;
      6'd7:  res = XLEN'($signed(num1) >>> sh);
      6'd8:  res = (num1 << sh) | (num1 >> rsh);
      6'd9:  res = (num1 >> sh) | (num1 << rsh);
      6'd10: res = XLEN'($signed(num1) <  $signed(num2));
      6'd11: res = XLEN'($signed(num1) >  $signed(num2));
      6'd12: res = XLEN'($signed(num1) <= $signed(num2));
      6'd13: res = XLEN'($signed(num1) >= $signed(num2));
      6'd14: res = XLEN'(num1 >  num2);
      6'd15: res = XLEN'(num1 <  num2);
      6'd16: res = XLEN'(num1 <= num2);
      6'd17: res = XLEN'(num1 >= num2);
      default: res = '0;
    endcase
    if (bad) begin
      res = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_LOAD;
      beat_q      <= '0;
      instr_q     <= '0;
      sr_q        <= '0;
      chunk_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      illegal_q   <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (in_valid) begin
            instr_q[beat_q*BUS_W +: BUS_W] <= in_data;
            if (beat_q == BW'(NBEATS-1)) begin
              beat_q  <= '0;
              state_q <= S_EXEC;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        S_EXEC: begin
          illegal_q   <= bad;
          sr_q        <= res;
          out_data_q  <= OUT_W'(res);
          out_valid_q <= 1'b1;
          out_last_q  <= (NCH == 1);
          chunk_q     <= '0;
          state_q     <= S_DRAIN;
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (out_last_q) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              out_data_q  <= '0;
              state_q     <= S_LOAD;
            end else begin
              // sr_q always holds the chunk on out_data in its low bits
              sr_q       <= sr_q >> OUT_W;
              out_data_q <= OUT_W'(sr_q >> OUT_W);
              chunk_q    <= chunk_q + 1'b1;
              out_last_q <= (chunk_q == CW'(NCH-2));
            end
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  // Writeback is issued after the host write so it wins on an address collision
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      if (rf_we && (rf_waddr != 5'd0) && (int'(rf_waddr) < NREGS)) begin
        rf_q[rf_waddr] <= rf_wdata;
      end
      if ((state_q == S_EXEC) && !bad && (rd != 5'd0)) begin
        rf_q[rd] <= res;
      end
    end
  end

  assign in_ready  = (state_q == S_LOAD);
  assign busy      = (state_q == S_EXEC) || (state_q == S_DRAIN);
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_rtype_alu_exec.sv
// tb/tb_rtype_alu_exec.sv - scoreboard bench for rtype_alu_exec with directed vectors
module tb_rtype_alu_exec;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;
  logic        illegal;

  int n_checks = 0;
  int n_pass   = 0;
  logic [16:0] sb [$];

  rtype_alu_exec #(.XLEN(32), .BUS_W(8), .NREGS(32), .OUT_W(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endfunction

  // Monitor: a handshake seen before the rising edge consumes the oldest expectation
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_chunk: got 0x%04h expected no output", out_data);
      end else begin
        logic [16:0] e;
        e = sb.pop_front();
        chk("chunk_data", {16'd0, out_data}, {16'd0, e[15:0]});
        chk("chunk_last", {31'd0, out_last}, {31'd0, e[16]});
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL in_ready_timeout: got in_ready=0 expected 1 within 500 cycles");
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (sb.size() != 0 || !in_ready) begin
      n_checks++;
      $display("FAIL drain_timeout: got %0d pending chunks expected 0", sb.size());
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    rf_we = 1'b1; rf_waddr = a; rf_wdata = d;
    @(posedge clk); #1;
    rf_we = 1'b0;
  endtask

  task automatic send(input logic [5:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic [5:0] fn, input logic [31:0] exp,
                      input bit collide);
    logic [31:0] ins;
    ins = {op, rs1, rs2, rd, 5'd0, fn};
    sb.push_back({1'b0, exp[15:0]});
    sb.push_back({1'b1, exp[31:16]});
    for (int b = 0; b < 4; b++) begin
      wait_ready();
      in_valid = 1'b1;
      in_data  = ins[b*8 +: 8];
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    chk("exec_busy", {31'd0, busy}, 32'd1);
    chk("exec_no_valid", {31'd0, out_valid}, 32'd0);
    if (collide) begin
      rf_we = 1'b1; rf_waddr = rd; rf_wdata = 32'hDEADBEEF;
    end
    @(posedge clk); #1;
    rf_we = 1'b0;
    chk("valid_at_t2", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic run(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                     input logic [5:0] fn, input logic [31:0] exp);
    send(6'd0, rs1, rs2, rd, fn, exp, 1'b0);
    drain();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; rf_we = 1'b0;
    rf_waddr = '0; rf_wdata = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_last",  {31'd0, out_last}, 32'd0);
    chk("rst_out_data",  {16'd0, out_data}, 32'd0);
    chk("rst_busy",      {31'd0, busy}, 32'd0);
    chk("rst_illegal",   {31'd0, illegal}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);

    // ADD with carry across the chunk boundary, then read r3 back through the ALU
    wr(5'd1, 32'h0001FFFF); wr(5'd2, 32'd1);
    run(5'd1, 5'd2, 5'd3, 6'd0, 32'h00020000);
    run(5'd3, 5'd0, 5'd5, 6'd0, 32'h00020000);

    wr(5'd1, 32'h80000000); wr(5'd2, 32'd4);
    run(5'd1, 5'd2, 5'd4, 6'd7, 32'hF8000000);
    run(5'd1, 5'd2, 5'd4, 6'd6, 32'h08000000);
    run(5'd1, 5'd0, 5'd4, 6'd8, 32'h80000000);
    run(5'd1, 5'd2, 5'd4, 6'd8, 32'h00000008);
    run(5'd1, 5'd2, 5'd4, 6'd9, 32'h08000000);
    run(5'd1, 5'd2, 5'd4, 6'd5, 32'h00000000);
    run(5'd2, 5'd1, 5'd6, 6'd1, 32'h80000004);

    wr(5'd1, 32'hFFFFFFFF); wr(5'd2, 32'd1);
    run(5'd1, 5'd2, 5'd4, 6'd10, 32'd1);
    run(5'd1, 5'd2, 5'd4, 6'd15, 32'd0);
    run(5'd1, 5'd2, 5'd4, 6'd17, 32'd1);
    run(5'd1, 5'd2, 5'd4, 6'd13, 32'd0);
    run(5'd1, 5'd2, 5'd4, 6'd11, 32'd0);
    run(5'd1, 5'd2, 5'd4, 6'd14, 32'd1);
    run(5'd1, 5'd2, 5'd4, 6'd12, 32'd1);
    run(5'd1, 5'd2, 5'd4, 6'd16, 32'd0);
    run(5'd1, 5'd2, 5'd4, 6'd2, 32'd1);
    run(5'd1, 5'd2, 5'd4, 6'd3, 32'hFFFFFFFF);
    run(5'd1, 5'd2, 5'd4, 6'd4, 32'hFFFFFFFE);
    run(5'd1, 5'd2, 5'd4, 6'd0, 32'h00000000);

    // Illegal func and illegal opcode both target r3, which must keep 0x00020000
    send(6'd0, 5'd1, 5'd2, 5'd3, 6'h3F, 32'd0, 1'b0); drain();
    chk("illegal_func", {31'd0, illegal}, 32'd1);
    send(6'd1, 5'd1, 5'd2, 5'd3, 6'd0, 32'd0, 1'b0); drain();
    chk("illegal_opcode", {31'd0, illegal}, 32'd1);
    run(5'd3, 5'd0, 5'd5, 6'd0, 32'h00020000);
    chk("illegal_cleared", {31'd0, illegal}, 32'd0);

    // Backpressure: hold the second chunk for five cycles
    out_ready = 1'b0;
    send(6'd0, 5'd3, 5'd0, 5'd7, 6'd0, 32'h00020000, 1'b0);
    chk("stall_chunk0", {16'd0, out_data}, 32'h0000);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_data",     {16'd0, out_data}, 32'h0002);
      chk("stall_last",     {31'd0, out_last}, 32'd1);
      chk("stall_valid",    {31'd0, out_valid}, 32'd1);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drain();

    // Host write to r3 collides with writeback of r3 = r2 + r2
    send(6'd0, 5'd2, 5'd2, 5'd3, 6'd0, 32'd2, 1'b1); drain();
    run(5'd3, 5'd0, 5'd5, 6'd0, 32'd2);

    run(5'd2, 5'd2, 5'd0, 6'd0, 32'd2);
    run(5'd0, 5'd2, 5'd5, 6'd0, 32'd1);

    // Reset while in DRAIN drops the result and clears the register file
    out_ready = 1'b0;
    send(6'd0, 5'd2, 5'd2, 5'd3, 6'd0, 32'd2, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    chk("rst_drain_valid",    {31'd0, out_valid}, 32'd0);
    chk("rst_drain_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_drain_busy",     {31'd0, busy}, 32'd0);
    chk("rst_drain_last",     {31'd0, out_last}, 32'd0);
    out_ready = 1'b1;
    run(5'd3, 5'd1, 5'd5, 6'd0, 32'd0);
    run(5'd4, 5'd7, 5'd5, 6'd0, 32'd0);
    run(5'd2, 5'd6, 5'd5, 6'd3, 32'd0);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
